// File: rtl/r30_keystream_engine.sv
// -----------------------------------------------------------------------------
// r30_keystream_engine
//   Sequential Rule 30 keystream generator. A seed row of N cells is loaded and
//   evolved for D generations, one generation per clock, on a cyclic ring. The
//   final row is presented as the keystream word with a valid/ready handshake.
//
//   Parameters
//     N  cell count, seed and keystream width (N >= 3)
//     D  generations per seed (D >= 1)
//
//   Ports
//     clk           in   rising-edge clock
//     rst           in   asynchronous reset, active-high
//     in_valid      in   seed offered
//     in_ready      out  engine can accept a seed (IDLE only)
//     seed          in   [N-1:0] initial row, sampled on in_valid && in_ready
//     out_valid     out  keystream word available (DONE)
//     out_ready     in   downstream accepts keystream
//     keystream     out  [N-1:0] row after D generations, stable while out_valid
//     busy          out  high while generations are being computed
//     column_slice  out  [D-1:0] centre-cell history (COLUMN_SLICE_EN only)
//
//   Build option
//     COLUMN_SLICE_EN  when defined, adds the column_slice port and the D-bit
//                      history register; handshake and timing are unchanged.
// -----------------------------------------------------------------------------
module r30_keystream_engine #(
    parameter int N = 128,
    parameter int D = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] seed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] keystream,
`ifdef COLUMN_SLICE_EN
    output logic [D-1:0] column_slice,
`endif
    output logic         busy
);

    localparam int CW = $clog2(D + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  row_q, row_d;
    logic [N-1:0]  nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_gen;

    // Generation index D-1 is the final update of this seed.
    assign last_gen = (cnt_q == CW'(D - 1));

    // Rule 30 on a ring: the left neighbour of cell i is i+1, the right is i-1.
    for (genvar i = 0; i < N; i++) begin : g_cell
        localparam int L = (i + 1) % N;
        localparam int R = (i + N - 1) % N;
        assign nxt[i] = row_q[L] ^ (row_q[i] | row_q[R]);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_gen)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    always_comb begin
        row_d = row_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    row_d = seed;
                    cnt_d = '0;
                end
            end
            RUN: begin
                row_d = nxt;
                // Return to zero on the last update so cnt stays within 0..D-1.
                cnt_d = last_gen ? '0 : cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            cnt_q <= '0;
        end else begin
            row_q <= row_d;
            cnt_q <= cnt_d;
        end
    end

    // Keystream is the row register itself; it only changes on load or in RUN.
    assign keystream = row_q;

`ifdef COLUMN_SLICE_EN
    logic [D-1:0] cs_q, cs_d;

    // Bit k records the centre cell produced by update k.
    always_comb begin
        cs_d = cs_q;
        case (state_q)
            IDLE: if (in_valid) cs_d = '0;
            RUN: begin
                for (int k = 0; k < D; k++) begin
                    if (cnt_q == CW'(k)) cs_d[k] = nxt[N/2];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cs_q <= '0;
        else     cs_q <= cs_d;
    end

    assign column_slice = cs_q;
`endif

endmodule

// File: tb/tb_r30_keystream_engine.sv
// -----------------------------------------------------------------------------
// tb_r30_keystream_engine
//   Two engines: a small one (N=8, D=2) for directed and randomized handshake
//   traffic, and a full-size one (N=128, D=256) for back-to-back seeds.
//   A timestamp model predicts in_ready/out_valid/busy each cycle and the
//   expected keystream is computed with a Wolfram rule-number lookup.
// -----------------------------------------------------------------------------
module tb_r30_keystream_engine;

    localparam int NN [2] = '{8, 128};
    localparam int DD [2] = '{2, 256};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         ivld [2];
    logic         ordy [2];
    logic         irdy [2];
    logic         ovld [2];
    logic         bsy  [2];
    logic [127:0] sd   [2];
    logic [127:0] ks   [2];
    logic [7:0]   ks_a;
    logic [127:0] ks_b;
    logic [7:0]   sd_a;

    assign ks[0] = {120'b0, ks_a};
    assign ks[1] = ks_b;
    assign sd_a  = sd[0][7:0];

`ifdef COLUMN_SLICE_EN
    logic [1:0]   cs_a;
    logic [255:0] cs_b;
    logic [255:0] cs [2];
    assign cs[0] = {254'b0, cs_a};
    assign cs[1] = cs_b;
`endif

    r30_keystream_engine #(.N(8), .D(2)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (ivld[0]),
        .in_ready    (irdy[0]),
        .seed        (sd_a),
        .out_valid   (ovld[0]),
        .out_ready   (ordy[0]),
        .keystream   (ks_a),
`ifdef COLUMN_SLICE_EN
        .column_slice(cs_a),
`endif
        .busy        (bsy[0])
    );

    r30_keystream_engine #(.N(128), .D(256)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (ivld[1]),
        .in_ready    (irdy[1]),
        .seed        (sd[1]),
        .out_valid   (ovld[1]),
        .out_ready   (ordy[1]),
        .keystream   (ks_b),
`ifdef COLUMN_SLICE_EN
        .column_slice(cs_b),
`endif
        .busy        (bsy[1])
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    bit chk_en = 1'b0;
    bit b2b [2] = '{1'b0, 1'b1};

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [127:0] step(input logic [127:0] r, input int n);
        logic [7:0]   rule;
        logic [127:0] o;
        rule = 8'd30;
        o    = '0;
        for (int i = 0; i < n; i++)
            o[i] = rule[{r[(i + 1) % n], r[i], r[(i + n - 1) % n]}];
        return o;
    endfunction

    function automatic logic [127:0] evolve(input logic [127:0] s, input int n, input int d);
        logic [127:0] r;
        r = s;
        for (int k = 0; k < d; k++) r = step(r, n);
        return r;
    endfunction

    function automatic logic [255:0] colhist(input logic [127:0] s, input int n, input int d);
        logic [127:0] r;
        logic [255:0] h;
        r = s;
        h = '0;
        for (int k = 0; k < d; k++) begin
            r    = step(r, n);
            h[k] = r[n/2];
        end
        return h;
    endfunction

    // ---------------- compare process ----------------
    bit           pend    [2];
    int           tacc    [2];
    int           lastacc [2];
    logic [127:0] eks     [2];
    logic [255:0] ecs     [2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            pend[u]    = 1'b0;
            tacc[u]    = 0;
            lastacc[u] = -1;
            eks[u]     = '0;
            ecs[u]     = '0;
        end
        forever begin
            @(negedge clk);
            if (rst || !chk_en) begin
                pend[0] = 1'b0;
                pend[1] = 1'b0;
            end else begin
                for (int u = 0; u < 2; u++) begin
                    bit de;
                    bit acc;
                    de = pend[u] && (cyc >= tacc[u] + DD[u]);
                    chk($sformatf("in_ready[%0d]", u),  {255'b0, irdy[u]}, {255'b0, !pend[u]});
                    chk($sformatf("out_valid[%0d]", u), {255'b0, ovld[u]}, {255'b0, de});
                    chk($sformatf("busy[%0d]", u),      {255'b0, bsy[u]},  {255'b0, pend[u] && !de});
                    if (de) begin
                        chk($sformatf("keystream[%0d]", u), {128'b0, ks[u]}, {128'b0, eks[u]});
`ifdef COLUMN_SLICE_EN
                        chk($sformatf("column_slice[%0d]", u), cs[u], ecs[u]);
`endif
                    end
                    acc = !pend[u] && ivld[u];
                    if (de && ordy[u]) pend[u] = 1'b0;
                    if (acc) begin
                        if (b2b[u] && lastacc[u] >= 0)
                            chk($sformatf("spacing[%0d]", u), 256'(cyc + 1 - lastacc[u]), 256'(DD[u] + 2));
                        pend[u]    = 1'b1;
                        tacc[u]    = cyc + 1;
                        lastacc[u] = cyc + 1;
                        eks[u]     = evolve(sd[u], NN[u], DD[u]);
                        ecs[u]     = colhist(sd[u], NN[u], DD[u]);
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_for(input int u, input bit want_ovld, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (want_ovld ? ovld[u] : irdy[u]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo($sformatf("wait_%s[%0d]", want_ovld ? "out_valid" : "in_ready", u));
    endtask

    // Loads a seed into the small engine; hold>0 stalls DONE with in_valid high.
    task automatic run_a(input logic [7:0] seed, input int hold, output logic [7:0] got);
        bit ok;
        sd[0]   = {120'b0, seed};
        ivld[0] = 1'b1;
        ordy[0] = 1'b0;
        wait_for(0, 1'b0, ok);
        @(posedge clk); #1;
        if (hold == 0) ivld[0] = 1'b0;
        wait_for(0, 1'b1, ok);
        got = ks[0][7:0];
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        ivld[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
    endtask

    task automatic run_a_rand();
        bit ok;
        bit hs;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        sd[0]   = {120'b0, 8'($urandom)};
        ivld[0] = 1'b1;
        wait_for(0, 1'b0, ok);
        @(posedge clk); #1;
        ivld[0] = 1'b0;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            ordy[0] = 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = ovld[0] && ordy[0];
            @(posedge clk); #1;
        end
        ordy[0] = 1'b0;
        if (!hs) tmo("rand_handshake");
    endtask

    task automatic run_b();
        bit ok;
        logic [127:0] s [4];
        s[0] = 128'h1 << 64;
        for (int j = 1; j < 4; j++) s[j] = {$urandom, $urandom, $urandom, $urandom};
        ordy[1] = 1'b1;
        sd[1]   = s[0];
        ivld[1] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_for(1, 1'b0, ok);
            @(posedge clk); #1;
            if (j < 3) sd[1] = s[j + 1];
        end
        ivld[1] = 1'b0;
        wait_for(1, 1'b1, ok);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] got;
        bit ok;
        for (int u = 0; u < 2; u++) begin
            ivld[u] = 1'b0;
            ordy[u] = 1'b0;
            sd[u]   = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst_out_valid[%0d]", u), {255'b0, ovld[u]}, 256'b0);
            chk($sformatf("rst_busy[%0d]", u),      {255'b0, bsy[u]},  256'b0);
            chk($sformatf("rst_keystream[%0d]", u), {128'b0, ks[u]},   256'b0);
`ifdef COLUMN_SLICE_EN
            chk($sformatf("rst_column_slice[%0d]", u), cs[u], 256'b0);
`endif
        end
        @(posedge clk); #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Hand-computed values pinning the model.
        chk("model_n8_d1", {128'b0, evolve(128'h01, 8, 1)}, 256'h83);
        chk("model_n8_d2", {128'b0, evolve(128'h01, 8, 2)}, 256'h46);
        chk("model_n8_d4_zero", {128'b0, evolve(128'h00, 8, 4)}, 256'h00);
        chk("model_col_n8_d2", colhist(128'h01, 8, 2), 256'b0);

        run_a(8'h01, 0, got);
        chk("seed01_keystream", {248'b0, got}, 256'h46);
        run_a(8'h00, 0, got);
        chk("seed00_keystream", {248'b0, got}, 256'h00);
        run_a(8'hA5, 5, got);

        // Reset after the first generation of a run.
        sd[0]   = 128'h01;
        ivld[0] = 1'b1;
        wait_for(0, 1'b0, ok);
        @(posedge clk); #1;
        ivld[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {255'b0, ovld[0]}, 256'b0);
        chk("abort_in_ready",  {255'b0, irdy[0]}, 256'b1);
        @(posedge clk); #1;
        run_a(8'h01, 0, got);
        chk("post_abort_keystream", {248'b0, got}, 256'h46);

        for (int it = 0; it < 30; it++) run_a_rand();

        run_b();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
